// File: rtl/rvh_l1d_ptw_req_arb.sv
// PTW request front-end for the L1D load pipe: issues one walk at a time and re-issues
// replays from the replay buffer. It also tracks timeouts, replay counts and protocol errors.
module rvh_l1d_ptw_req_arb #(
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int REPLAY_CNT_WIDTH = 4,
  parameter int PTW_ID_WIDTH     = 4,
  parameter int PADDR_WIDTH      = 56
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ptw_req_vld_i,
  input  logic [PTW_ID_WIDTH-1:0]     ptw_req_id_i,
  input  logic [PADDR_WIDTH-1:0]      ptw_req_paddr_i,
  output logic                        ptw_req_rdy_o,
  output logic                        alloc_vld_o,
  output logic [PTW_ID_WIDTH-1:0]     alloc_id_o,
  output logic [PADDR_WIDTH-1:0]      alloc_paddr_o,
  input  logic                        replay_vld_i,
  input  logic [PTW_ID_WIDTH-1:0]     replay_id_i,
  input  logic [PADDR_WIDTH-1:0]      replay_paddr_i,
  output logic                        replay_rdy_o,
  output logic                        l1d_req_vld_o,
  output logic [PTW_ID_WIDTH-1:0]     l1d_req_id_o,
  output logic [PADDR_WIDTH-1:0]      l1d_req_paddr_o,
  output logic                        l1d_req_is_replay_o,
  input  logic                        l1d_req_rdy_i,
  input  logic                        ptw_walk_resp_vld_i,
  input  logic                        ptw_walk_resp_rdy_i,
  output logic                        timeout_o,
  output logic                        protocol_err_o,
  output logic [REPLAY_CNT_WIDTH-1:0] replay_cnt_o
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                      state;
  logic [PTW_ID_WIDTH-1:0]     issue_id;
  logic [PTW_ID_WIDTH-1:0]     walk_id;
  logic [PADDR_WIDTH-1:0]      issue_paddr;
  logic                        issue_is_replay;
  logic [TCNT_W-1:0]           tcnt;
  logic [REPLAY_CNT_WIDTH-1:0] replay_cnt;
  logic                        protocol_err;

  logic resp_hs, req_hs, l1d_hs, rpl_hs, err_set;

  assign ptw_req_rdy_o = (state == IDLE);
  // A completing response wins over a simultaneous replay, so the replay is refused.
  assign replay_rdy_o  = (state == WAIT) & ~resp_hs;
  assign l1d_req_vld_o = (state == ISSUE);

  assign resp_hs = ptw_walk_resp_vld_i & ptw_walk_resp_rdy_i;
  assign req_hs  = ptw_req_vld_i & ptw_req_rdy_o;
  assign l1d_hs  = l1d_req_vld_o & l1d_req_rdy_i;
  assign rpl_hs  = replay_vld_i & replay_rdy_o;

  assign alloc_vld_o   = req_hs;
  assign alloc_id_o    = ptw_req_id_i;
  assign alloc_paddr_o = ptw_req_paddr_i;

  assign l1d_req_id_o        = issue_id;
  assign l1d_req_paddr_o     = issue_paddr;
  assign l1d_req_is_replay_o = issue_is_replay;

  assign timeout_o      = (state == WAIT) && (tcnt == TCNT_W'(TIMEOUT_CYCLES));
  assign protocol_err_o = protocol_err;
  assign replay_cnt_o   = replay_cnt;

  assign err_set = (resp_hs && (state != WAIT))
                 | (rpl_hs && (replay_id_i != walk_id))
                 | (replay_vld_i && (state == IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      issue_id        <= '0;
      walk_id         <= '0;
      issue_paddr     <= '0;
      issue_is_replay <= 1'b0;
      tcnt            <= '0;
      replay_cnt      <= '0;
      protocol_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            issue_id        <= ptw_req_id_i;
            walk_id         <= ptw_req_id_i;
            issue_paddr     <= ptw_req_paddr_i;
            issue_is_replay <= 1'b0;
            replay_cnt      <= '0;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (l1d_hs) state <= WAIT;
        end
        WAIT: begin
          if (resp_hs) begin
            state <= IDLE;
          end else if (rpl_hs) begin
            issue_id        <= replay_id_i;
            issue_paddr     <= replay_paddr_i;
            issue_is_replay <= 1'b1;
            if (replay_cnt != '1) replay_cnt <= replay_cnt + 1'b1;
            state           <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase

      // Counter only runs in WAIT; any visit to ISSUE restarts it from zero.
      if (state != WAIT) tcnt <= '0;
      else if (tcnt != TCNT_W'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;

      protocol_err <= protocol_err | err_set;
    end
  end

endmodule

// File: tb/tb_rvh_l1d_ptw_req_arb.sv
// Randomized scoreboard bench for rvh_l1d_ptw_req_arb: a driver issues walks/replays and queues
// the expected allocations and load-pipe issues; a monitor pops and compares on every handshake.
module tb_rvh_l1d_ptw_req_arb;

  localparam int T   = 8;
  localparam int RW  = 4;
  localparam int IW  = 4;
  localparam int PW  = 56;
  localparam int LW  = IW + PW + 1;
  localparam int SAT = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ptw_req_vld_i;
  logic [IW-1:0] ptw_req_id_i;
  logic [PW-1:0] ptw_req_paddr_i;
  logic          ptw_req_rdy_o;
  logic          alloc_vld_o;
  logic [IW-1:0] alloc_id_o;
  logic [PW-1:0] alloc_paddr_o;
  logic          replay_vld_i;
  logic [IW-1:0] replay_id_i;
  logic [PW-1:0] replay_paddr_i;
  logic          replay_rdy_o;
  logic          l1d_req_vld_o;
  logic [IW-1:0] l1d_req_id_o;
  logic [PW-1:0] l1d_req_paddr_o;
  logic          l1d_req_is_replay_o;
  logic          l1d_req_rdy_i;
  logic          ptw_walk_resp_vld_i;
  logic          ptw_walk_resp_rdy_i;
  logic          timeout_o;
  logic          protocol_err_o;
  logic [RW-1:0] replay_cnt_o;

  rvh_l1d_ptw_req_arb #(
    .TIMEOUT_CYCLES(T), .REPLAY_CNT_WIDTH(RW), .PTW_ID_WIDTH(IW), .PADDR_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .ptw_req_vld_i(ptw_req_vld_i), .ptw_req_id_i(ptw_req_id_i),
    .ptw_req_paddr_i(ptw_req_paddr_i), .ptw_req_rdy_o(ptw_req_rdy_o),
    .alloc_vld_o(alloc_vld_o), .alloc_id_o(alloc_id_o), .alloc_paddr_o(alloc_paddr_o),
    .replay_vld_i(replay_vld_i), .replay_id_i(replay_id_i),
    .replay_paddr_i(replay_paddr_i), .replay_rdy_o(replay_rdy_o),
    .l1d_req_vld_o(l1d_req_vld_o), .l1d_req_id_o(l1d_req_id_o),
    .l1d_req_paddr_o(l1d_req_paddr_o), .l1d_req_is_replay_o(l1d_req_is_replay_o),
    .l1d_req_rdy_i(l1d_req_rdy_i),
    .ptw_walk_resp_vld_i(ptw_walk_resp_vld_i), .ptw_walk_resp_rdy_i(ptw_walk_resp_rdy_i),
    .timeout_o(timeout_o), .protocol_err_o(protocol_err_o), .replay_cnt_o(replay_cnt_o)
  );

  always #5 clk = ~clk;

  logic [LW-1:0]   exp_l1d[$];
  logic [LW-2:0]   exp_alloc[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              model_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor samples on the falling edge, midway between driver updates and the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (alloc_vld_o) begin
          if (exp_alloc.size() == 0) checkOutput("alloc_unexpected", 64'(alloc_id_o), 64'hdead);
          else checkOutput("alloc", 64'({alloc_id_o, alloc_paddr_o}), 64'(exp_alloc.pop_front()));
        end
        if (l1d_req_vld_o && l1d_req_rdy_i) begin
          if (exp_l1d.size() == 0) checkOutput("l1d_unexpected", 64'(l1d_req_id_o), 64'hdead);
          else checkOutput("l1d_issue",
                           64'({l1d_req_id_o, l1d_req_paddr_o, l1d_req_is_replay_o}),
                           64'(exp_l1d.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Holds a request in the load-pipe slot for bp stalled cycles, then lets it go.
  task automatic issuePhase(input logic [IW-1:0] id, input logic [PW-1:0] paddr,
                            input logic isr, input int bp);
    for (int i = 0; i <= bp; i++) begin
      checkOutput("issue_vld", 64'(l1d_req_vld_o), 64'd1);
      checkOutput("issue_hold", 64'({l1d_req_id_o, l1d_req_paddr_o, l1d_req_is_replay_o}),
                  64'({id, paddr, isr}));
      checkOutput("issue_req_rdy", 64'(ptw_req_rdy_o), 64'd0);
      checkOutput("issue_replay_rdy", 64'(replay_rdy_o), 64'd0);
      ptw_req_vld_i   = 1'($urandom_range(0, 1));
      ptw_req_id_i    = IW'($urandom);
      ptw_req_paddr_i = PW'({$urandom, $urandom});
      l1d_req_rdy_i   = (i == bp);
      waitCycle();
    end
    l1d_req_rdy_i = 1'b0;
    ptw_req_vld_i = 1'b0;
  endtask

  // Spends n cycles in WAIT; timeout must show once T full cycles have passed there.
  task automatic waitPhase(input int n);
    for (int k = 0; k < n; k++) begin
      checkOutput("timeout", 64'(timeout_o), 64'(k >= T));
      checkOutput("wait_replay_rdy", 64'(replay_rdy_o), 64'd1);
      checkOutput("wait_req_rdy", 64'(ptw_req_rdy_o), 64'd0);
      waitCycle();
    end
  endtask

  task automatic applyStimulus(input logic [IW-1:0] id, input logic [PW-1:0] paddr,
                               input int bp, input int nrep, input int wcyc, input bit simul);
    logic [PW-1:0] rp;
    checkOutput("idle_req_rdy", 64'(ptw_req_rdy_o), 64'd1);
    checkOutput("idle_replay_cnt_held", 64'(replay_cnt_o), 64'(model_cnt));
    ptw_req_vld_i   = 1'b1;
    ptw_req_id_i    = id;
    ptw_req_paddr_i = paddr;
    exp_alloc.push_back({id, paddr});
    exp_l1d.push_back({id, paddr, 1'b0});
    model_cnt = 0;
    waitCycle();
    ptw_req_vld_i = 1'b0;
    issuePhase(id, paddr, 1'b0, bp);
    for (int r = 0; r < nrep; r++) begin
      waitPhase($urandom_range(0, 2));
      rp             = PW'({$urandom, $urandom});
      replay_vld_i   = 1'b1;
      replay_id_i    = id;
      replay_paddr_i = rp;
      #1;
      checkOutput("replay_rdy", 64'(replay_rdy_o), 64'd1);
      exp_l1d.push_back({id, rp, 1'b1});
      model_cnt = (model_cnt + 1 > SAT) ? SAT : model_cnt + 1;
      waitCycle();
      replay_vld_i = 1'b0;
      checkOutput("replay_cnt", 64'(replay_cnt_o), 64'(model_cnt));
      issuePhase(id, rp, 1'b1, $urandom_range(0, 1));
    end
    waitPhase(wcyc);
    ptw_walk_resp_vld_i = 1'b1;
    ptw_walk_resp_rdy_i = 1'b1;
    replay_vld_i        = simul;
    replay_id_i         = id;
    #1;
    checkOutput("resp_replay_rdy", 64'(replay_rdy_o), 64'd0);
    waitCycle();
    ptw_walk_resp_vld_i = 1'b0;
    ptw_walk_resp_rdy_i = 1'b0;
    replay_vld_i        = 1'b0;
    checkOutput("done_req_rdy", 64'(ptw_req_rdy_o), 64'd1);
    checkOutput("done_l1d_vld", 64'(l1d_req_vld_o), 64'd0);
    checkOutput("done_timeout", 64'(timeout_o), 64'd0);
    checkOutput("done_replay_cnt", 64'(replay_cnt_o), 64'(model_cnt));
    checkOutput("done_protocol_err", 64'(protocol_err_o), 64'd0);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_l1d.delete();
    exp_alloc.delete();
    model_cnt = 0;
    waitCycle();
    checkOutput("post_reset_err", 64'(protocol_err_o), 64'd0);
  endtask

  initial begin
    rst                 = 1'b0;
    ptw_req_vld_i       = 1'b0;
    ptw_req_id_i        = '0;
    ptw_req_paddr_i     = '0;
    replay_vld_i        = 1'b0;
    replay_id_i         = '0;
    replay_paddr_i      = '0;
    l1d_req_rdy_i       = 1'b0;
    ptw_walk_resp_vld_i = 1'b0;
    ptw_walk_resp_rdy_i = 1'b0;
    #2;
    checkOutput("rst_req_rdy", 64'(ptw_req_rdy_o), 64'd1);
    checkOutput("rst_l1d_vld", 64'(l1d_req_vld_o), 64'd0);
    checkOutput("rst_replay_rdy", 64'(replay_rdy_o), 64'd0);
    checkOutput("rst_alloc_vld", 64'(alloc_vld_o), 64'd0);
    checkOutput("rst_flags", 64'({timeout_o, protocol_err_o, l1d_req_is_replay_o}), 64'd0);
    checkOutput("rst_regs", 64'({replay_cnt_o, l1d_req_id_o}), 64'd0);
    checkOutput("rst_paddr", 64'(l1d_req_paddr_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    waitCycle();

    applyStimulus(4'd3, 56'h8000_1000, 0, 0, 5, 1'b0);
    applyStimulus(4'd6, 56'h1234_5678, 4, 0, 2, 1'b0);
    applyStimulus(4'd3, 56'h4000_0040, 0, 2, 2, 1'b0);
    applyStimulus(4'd2, 56'h0abc_d000, 1, 1, 3, 1'b1);
    applyStimulus(4'd9, 56'h0000_0ff8, 0, 0, T + 3, 1'b0);
    applyStimulus(4'd7, 56'hff_ffff_ffff_fff8, 0, SAT + 2, 1, 1'b0);
    for (int w = 0; w < 30; w++)
      applyStimulus(IW'($urandom), PW'({$urandom, $urandom}), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, T + 4), 1'($urandom_range(0, 1)));

    // Asynchronous reset while a request sits in ISSUE.
    ptw_req_vld_i   = 1'b1;
    ptw_req_id_i    = 4'd3;
    ptw_req_paddr_i = 56'h8000_2000;
    exp_alloc.push_back({4'd3, 56'h8000_2000});
    waitCycle();
    ptw_req_vld_i = 1'b0;
    checkOutput("pre_reset_issue", 64'(l1d_req_vld_o), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("async_l1d_vld", 64'(l1d_req_vld_o), 64'd0);
    checkOutput("async_req_rdy", 64'(ptw_req_rdy_o), 64'd1);
    checkOutput("async_regs", 64'({replay_cnt_o, l1d_req_id_o, l1d_req_is_replay_o}), 64'd0);
    checkOutput("async_paddr", 64'(l1d_req_paddr_o), 64'd0);
    checkOutput("async_flags", 64'({timeout_o, protocol_err_o, replay_rdy_o}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_alloc.delete();
    model_cnt = 0;
    waitCycle();

    // Response handshake with nothing outstanding.
    ptw_walk_resp_vld_i = 1'b1;
    ptw_walk_resp_rdy_i = 1'b1;
    waitCycle();
    ptw_walk_resp_vld_i = 1'b0;
    ptw_walk_resp_rdy_i = 1'b0;
    checkOutput("err_resp_idle", 64'(protocol_err_o), 64'd1);
    waitCycle();
    checkOutput("err_sticky", 64'(protocol_err_o), 64'd1);
    resetPulse();

    // Replay carrying a foreign id: still reissued, but flagged.
    ptw_req_vld_i   = 1'b1;
    ptw_req_id_i    = 4'd3;
    ptw_req_paddr_i = 56'h8000_3000;
    exp_alloc.push_back({4'd3, 56'h8000_3000});
    exp_l1d.push_back({4'd3, 56'h8000_3000, 1'b0});
    waitCycle();
    ptw_req_vld_i = 1'b0;
    l1d_req_rdy_i = 1'b1;
    waitCycle();
    l1d_req_rdy_i  = 1'b0;
    replay_vld_i   = 1'b1;
    replay_id_i    = 4'd5;
    replay_paddr_i = 56'h8000_3040;
    exp_l1d.push_back({4'd5, 56'h8000_3040, 1'b1});
    waitCycle();
    replay_vld_i = 1'b0;
    checkOutput("err_replay_id", 64'(protocol_err_o), 64'd1);
    l1d_req_rdy_i = 1'b1;
    waitCycle();
    l1d_req_rdy_i       = 1'b0;
    ptw_walk_resp_vld_i = 1'b1;
    ptw_walk_resp_rdy_i = 1'b1;
    waitCycle();
    ptw_walk_resp_vld_i = 1'b0;
    ptw_walk_resp_rdy_i = 1'b0;
    checkOutput("err_replay_sticky", 64'(protocol_err_o), 64'd1);
    checkOutput("l1d_queue_drained", 64'(exp_l1d.size()), 64'd0);
    resetPulse();

    // Replay valid while idle.
    replay_vld_i = 1'b1;
    replay_id_i  = 4'd1;
    #1;
    checkOutput("idle_replay_rdy", 64'(replay_rdy_o), 64'd0);
    waitCycle();
    replay_vld_i = 1'b0;
    checkOutput("err_replay_idle", 64'(protocol_err_o), 64'd1);
    resetPulse();

    checkOutput("alloc_queue_empty", 64'(exp_alloc.size()), 64'd0);
    checkOutput("l1d_queue_empty", 64'(exp_l1d.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
